// File: rtl/fetch_stage.sv
// fetch_stage: PC register, combinational imem fetch, small fetch queue toward decode
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [AW-1:0] head, tail;
    logic [AW:0] count;
    logic [31:0] q_pc [DEPTH];
    logic [31:0] q_pc4 [DEPTH];
    logic [31:0] q_instr [DEPTH];
    logic enq, deq;
    assign pc_plus4 = pc + 32'd4;
    assign imem_addr = pc;
    assign id_valid = count != '0;
    assign enq = !redirect_valid && count != FULL;
    assign deq = id_valid && id_ready && !redirect_valid;
    assign id_instr = id_valid ? q_instr[head] : '0;
    assign id_pc = id_valid ? q_pc[head] : '0;
    assign id_pc_plus4 = id_valid ? q_pc4[head] : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                pc <= pc_plus4;
                tail <= tail + 1'b1;
            end
            if (deq) head <= head + 1'b1;
            count <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
        end
    end
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[tail] <= pc;
            q_pc4[tail] <= pc_plus4;
            q_instr[tail] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run against a queue-based model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid, id_ready = 1'b0;
    logic [31:0] id_instr, id_pc, id_pc_plus4;
    int total = 0;
    int bad = 0;

    fetch_stage #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0062E233;
        if (a == 32'h4) return 32'h00B62423;
        return ((a ^ 32'h0000_5A5A) * 32'h9E37_79B1) ^ 32'h1234_5677;
    endfunction

    assign imem_rdata = memf(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t mq[$];
    logic [31:0] mpc = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] p, input logic y);
        logic full;
        logic ev;
        rst = r;
        redirect_valid = v;
        redirect_pc = p;
        id_ready = y;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mpc = 32'h0;
        end else if (v) begin
            mq.delete();
            mpc = p & ~32'h3;
        end else begin
            full = mq.size() == 2;
            if (mq.size() > 0 && y) void'(mq.pop_front());
            if (!full) begin
                mq.push_back('{pc: mpc, instr: memf(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        #1;
        ev = mq.size() != 0;
        chk("valid", {31'b0, id_valid}, {31'b0, ev});
        chk("addr", imem_addr, mpc);
        chk("instr", id_instr, ev ? mq[0].instr : 32'h0);
        chk("pc", id_pc, ev ? mq[0].pc : 32'h0);
        chk("pc4", id_pc_plus4, ev ? mq[0].pc + 32'd4 : 32'h0);
    endtask

    typedef struct {
        logic        r, v, y;
        logic [31:0] p;
        logic        ev;
        logic [31:0] epc, eaddr;
    } vec_t;
    vec_t vt[21];

    initial begin
        vt[0]  = '{1, 0, 1, 32'h0,        0, 32'h0,        32'h0};
        vt[1]  = '{0, 0, 1, 32'h0,        1, 32'h0,        32'h4};
        vt[2]  = '{0, 0, 1, 32'h0,        1, 32'h4,        32'h8};
        vt[3]  = '{1, 0, 0, 32'h0,        0, 32'h0,        32'h0};
        vt[4]  = '{0, 0, 0, 32'h0,        1, 32'h0,        32'h4};
        vt[5]  = '{0, 0, 0, 32'h0,        1, 32'h0,        32'h8};
        vt[6]  = '{0, 0, 0, 32'h0,        1, 32'h0,        32'h8};
        vt[7]  = '{0, 0, 0, 32'h0,        1, 32'h0,        32'h8};
        vt[8]  = '{0, 0, 0, 32'h0,        1, 32'h0,        32'h8};
        vt[9]  = '{0, 0, 1, 32'h0,        1, 32'h4,        32'h8};
        vt[10] = '{0, 0, 1, 32'h0,        1, 32'h8,        32'hC};
        vt[11] = '{0, 0, 0, 32'h0,        1, 32'h8,        32'h10};
        vt[12] = '{0, 1, 0, 32'h43,       0, 32'h0,        32'h40};
        vt[13] = '{0, 0, 1, 32'h0,        1, 32'h40,       32'h44};
        vt[14] = '{0, 1, 1, 32'h102,      0, 32'h0,        32'h100};
        vt[15] = '{0, 0, 1, 32'h0,        1, 32'h100,      32'h104};
        vt[16] = '{0, 0, 1, 32'h0,        1, 32'h104,      32'h108};
        vt[17] = '{0, 1, 0, 32'hFFFF_FFFC, 0, 32'h0,       32'hFFFF_FFFC};
        vt[18] = '{0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h0};
        vt[19] = '{0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h4};
        vt[20] = '{1, 0, 1, 32'h0,        0, 32'h0,        32'h0};
        for (int i = 0; i < 21; i++) begin
            step(vt[i].r, vt[i].v, vt[i].p, vt[i].y);
            chk($sformatf("vec%0d_valid", i), {31'b0, id_valid}, {31'b0, vt[i].ev});
            chk($sformatf("vec%0d_pc", i), id_pc, vt[i].epc);
            chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].eaddr);
            if (i == 18) chk("wrap_pc4", id_pc_plus4, 32'h0);
            if (i == 1) chk("first_instr", id_instr, 32'h0062E233);
            if (i == 2) chk("second_instr", id_instr, 32'h00B62423);
        end
        step(0, 1, 32'h200, 1);
        step(0, 1, 32'h300, 0);
        chk("b2b_redirect_addr", imem_addr, 32'h300);
        step(0, 0, 32'h0, 1);
        chk("b2b_redirect_pc", id_pc, 32'h300);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, tgt, $urandom_range(0, 2) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
